// File: rtl/mem_bus_pkg.sv
// Shared C2 bus types and default geometry for the line-fill/write-back master.
package mem_bus_pkg;
    localparam int ADDR_W    = 15;
    localparam int BUS_W     = 16;
    localparam int LINE_BITS = 128;
    localparam int BEATS     = LINE_BITS / BUS_W;

    typedef enum logic [1:0] {
        C2_NOP      = 2'd0,
        C2_RESPONSE = 2'd1,
        C2_READ     = 2'd2,
        C2_WRITE    = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_BEAT,
        WR_TURN,
        WR_WAIT,
        DONE
    } state_e;
endpackage

// File: rtl/line_serdes.sv
// Line <-> beat conversion: serialises a write-back line and assembles a fill
// line one BUS_W beat at a time, indexed by a shared beat counter.
module line_serdes #(
    parameter int BUS_W     = 16,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 capture,
    input  logic [LINE_BITS-1:0] line_in,
    input  logic [BUS_W-1:0]     beat_in,
    output logic [BUS_W-1:0]     beat_out,
    output logic                 last,
    output logic [LINE_BITS-1:0] line_out
);
    localparam int BEATS = LINE_BITS / BUS_W;
    localparam int CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0]              cnt;
    logic [BEATS-1:0][BUS_W-1:0]   shreg;
    logic [BEATS-1:0][BUS_W-1:0]   shreg_n;

    assign beat_out = shreg[cnt];
    assign last     = (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        shreg_n = shreg;
        if (capture)
            shreg_n[cnt] = beat_in;
    end

    // line_out only moves when a fill completes, so aborted or write
    // transactions leave the last good line visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            shreg    <= '0;
            line_out <= '0;
        end else if (load) begin
            cnt   <= '0;
            shreg <= line_in;
        end else if (step || capture) begin
            cnt   <= cnt + 1'b1;
            shreg <= shreg_n;
            if (capture && last)
                line_out <= shreg_n;
        end
    end
endmodule

// File: rtl/mem_bus_master.sv
// Cache-line master on the tri-state C2 bus: fills and write-backs in BUS_W beats.
// Optional watchdog on the wait states is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_master import mem_bus_pkg::*; #(
    parameter int ADDR_W    = mem_bus_pkg::ADDR_W,
    parameter int BUS_W     = mem_bus_pkg::BUS_W,
    parameter int LINE_BITS = mem_bus_pkg::LINE_BITS,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [LINE_BITS-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR_W-1:0]    c2_addr,
    inout  wire  [1:0]           c2_cmd,
    inout  wire  [BUS_W-1:0]     c2_data
);
    state_e            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic              cmd_oe, data_oe;
    c2_cmd_e           cmd_out;
    logic              load, step, capture, last, resp, timeout_hit;
    logic [BUS_W-1:0]  beat_out;

    assign resp    = (c2_cmd == C2_RESPONSE);
    assign c2_addr = addr_q;
    assign c2_cmd  = cmd_oe  ? cmd_out  : 2'bzz;
    assign c2_data = data_oe ? beat_out : {BUS_W{1'bz}};

    line_serdes #(.BUS_W(BUS_W), .LINE_BITS(LINE_BITS)) u_serdes (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .capture  (capture),
        .line_in  (req_wdata),
        .beat_in  (c2_data),
        .beat_out (beat_out),
        .last     (last),
        .line_out (rsp_rdata)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            waiting, err_q;

    assign waiting     = (state == RD_WAIT) || (state == WR_WAIT);
    assign timeout_hit = waiting && !resp && (to_cnt == TO_W'(TIMEOUT - 1));
    assign rsp_err     = err_q;

    // Held at zero outside the wait states, so it starts fresh on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (!waiting || resp) to_cnt <= '0;
            else                  to_cnt <= to_cnt + 1'b1;
            if (load)             err_q  <= 1'b0;
            else if (timeout_hit) err_q  <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state <= state_n;
            if (load) addr_q <= req_addr;
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        cmd_oe    = 1'b0;
        cmd_out   = C2_NOP;
        data_oe   = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                cmd_oe    = 1'b1;
                if (req_valid) begin
                    load    = 1'b1;
                    state_n = req_write ? WR_BEAT : RD_CMD;
                end
            end
            RD_CMD: begin
                cmd_oe  = 1'b1;
                cmd_out = C2_READ;
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (resp) begin
                    capture = 1'b1;
                    if (last) state_n = DONE;
                end else if (timeout_hit) begin
                    state_n = DONE;
                end
            end
            WR_BEAT: begin
                cmd_oe  = 1'b1;
                cmd_out = C2_WRITE;
                data_oe = 1'b1;
                step    = 1'b1;
                if (last) state_n = WR_TURN;
            end
            WR_TURN: state_n = WR_WAIT;
            WR_WAIT: if (resp || timeout_hit) state_n = DONE;
            DONE: begin
                rsp_valid = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master; the bench plays the C2 memory side of the bus.
module tb_mem_bus_master;
    localparam int TO = 255;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0, req_write = 1'b0;
    logic [14:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         req_ready, rsp_valid, rsp_err;
    logic [127:0] rsp_rdata;
    logic [14:0]  c2_addr;
    wire  [1:0]   c2_cmd;
    wire  [15:0]  c2_data;

    logic         tb_cmd_oe = 1'b0, tb_data_oe = 1'b0;
    logic [1:0]   tb_cmd = 2'd0;
    logic [15:0]  tb_data = 16'd0;
    logic [127:0] last_line = '0;
    int           tests = 0, fails = 0;

    assign c2_cmd  = tb_cmd_oe  ? tb_cmd  : 2'bzz;
    assign c2_data = tb_data_oe ? tb_data : 16'hzzzz;

    always #5 clk = ~clk;

    mem_bus_master #(.ADDR_W(15), .BUS_W(16), .LINE_BITS(128), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .c2_addr(c2_addr), .c2_cmd(c2_cmd), .c2_data(c2_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_drive(input logic [1:0] cmd, input logic [15:0] data);
        tb_cmd_oe = 1'b1; tb_cmd = cmd; tb_data_oe = 1'b1; tb_data = data;
    endtask

    task automatic mem_release();
        tb_cmd_oe = 1'b0; tb_data_oe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tb_data_oe = 1'b1; tb_data = 16'h3C3C;
        repeat (2) tick();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        tests++; if (rsp_rdata !== 128'd0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        tests++; if (c2_addr !== 15'd0) begin fails++; $display("FAIL reset_c2_addr: got %h want 0", c2_addr); end
        tests++; if (c2_cmd !== 2'd0) begin fails++; $display("FAIL reset_c2_cmd: got %0d want 0 (NOP)", c2_cmd); end
        tests++; if (c2_data !== 16'h3C3C) begin fails++; $display("FAIL reset_c2_data_released: got %h want 3c3c", c2_data); end
        reset = 1'b0;
        mem_release();
        tick();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    endtask

    // gap = number of NOP cycles the memory inserts after beat 4.
    task automatic test_read(input logic [14:0] addr, input logic [127:0] line, input int gap);
        bit early = 0;
        int k;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL read_ready_idle %h: got %b want 1", addr, req_ready); end
        tick();
        req_valid = 1'b0;
        tests++; if (c2_cmd !== 2'd2) begin fails++; $display("FAIL read_cmd %h: got %0d want 2 (READ)", addr, c2_cmd); end
        tests++; if (c2_addr !== addr) begin fails++; $display("FAIL read_c2_addr: got %h want %h", c2_addr, addr); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL read_ready_busy %h: got %b want 0", addr, req_ready); end
        for (int cyc = 0; cyc < 8 + gap; cyc++) begin
            tick();
            k = (cyc < 5) ? cyc : ((cyc < 5 + gap) ? -1 : cyc - gap);
            if (k >= 0) mem_drive(2'd1, line[16*k +: 16]);
            else        mem_drive(2'd0, 16'hDEAD);
            if (rsp_valid !== 1'b0) early = 1;
        end
        tick();
        mem_release();
        tests++; if (early) begin fails++; $display("FAIL read_early_rsp %h: got early rsp_valid want none", addr); end
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL read_rsp_valid %h: got %b want 1", addr, rsp_valid); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL read_rsp_err %h: got %b want 0", addr, rsp_err); end
        tests++; if (rsp_rdata !== line) begin fails++; $display("FAIL read_rdata %h: got %h want %h", addr, rsp_rdata, line); end
        tick();
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL read_after_done %h: got valid=%b ready=%b want 0/1", addr, rsp_valid, req_ready); end
        tests++; if (rsp_rdata !== line) begin fails++; $display("FAIL read_rdata_hold %h: got %h want %h", addr, rsp_rdata, line); end
        last_line = line;
    endtask

    // Write-back with req_valid held high and the request inputs changing while busy.
    task automatic test_write_busy();
        logic [15:0] exp_w [8] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123,
                                   16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h7FFF;
        req_wdata = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
        tick();
        req_addr = 15'h1234; req_wdata = {128{1'b1}}; req_write = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests++; if (c2_cmd !== 2'd3 || c2_data !== exp_w[k]) begin fails++; $display("FAIL write_beat%0d: got cmd=%0d data=%h want 3/%h", k, c2_cmd, c2_data, exp_w[k]); end
            tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL write_ready_beat%0d: got %b want 0", k, req_ready); end
            tick();
        end
        mem_drive(2'd0, 16'h5AA5);
        #1;
        tests++; if (c2_cmd !== 2'd0 || c2_data !== 16'h5AA5) begin fails++; $display("FAIL write_turn_released: got cmd=%0d data=%h want 0/5aa5", c2_cmd, c2_data); end
        tests++; if (c2_addr !== 15'h7FFF) begin fails++; $display("FAIL write_c2_addr: got %h want 7fff", c2_addr); end
        tick();
        mem_drive(2'd0, 16'h0000);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL write_wait_rsp: got %b want 0", rsp_valid); end
        tick();
        tick();
        mem_drive(2'd1, 16'h0000);
        tick();
        mem_release();
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin fails++; $display("FAIL write_done: got valid=%b err=%b want 1/0", rsp_valid, rsp_err); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL write_ready_done: got %b want 0", req_ready); end
        tests++; if (rsp_rdata !== last_line) begin fails++; $display("FAIL write_rdata_kept: got %h want %h", rsp_rdata, last_line); end
        req_valid = 1'b0;
        tick();
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || c2_cmd !== 2'd0) begin fails++; $display("FAIL write_single_txn: got valid=%b ready=%b cmd=%0d want 0/1/0", rsp_valid, req_ready, c2_cmd); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0033;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            mem_drive(2'd1, 16'h4000 + 16'(k));
        end
        #2 reset = 1'b1;
        tb_cmd_oe = 1'b0; tb_data = 16'h6996;
        #1;
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
        tests++; if (c2_cmd !== 2'd0 || c2_data !== 16'h6996) begin fails++; $display("FAIL rstmid_bus: got cmd=%0d data=%h want 0/6996", c2_cmd, c2_data); end
        tests++; if (c2_addr !== 15'd0 || rsp_rdata !== 128'd0) begin fails++; $display("FAIL rstmid_regs: got addr=%h rdata=%h want 0/0", c2_addr, rsp_rdata); end
        #1 reset = 1'b0;
        mem_release();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1;
        end
        tests++; if (seen) begin fails++; $display("FAIL rstmid_no_rsp: got rsp_valid or busy after reset want idle"); end
        last_line = '0;
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        bit early = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0042;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < TO; i++) begin
            if (rsp_valid !== 1'b0) early = 1;
            tick();
        end
        tests++; if (early) begin fails++; $display("FAIL timeout_early: got rsp_valid before %0d cycles", TO); end
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin fails++; $display("FAIL timeout_done: got valid=%b err=%b want 1/1", rsp_valid, rsp_err); end
        tests++; if (rsp_rdata !== last_line) begin fails++; $display("FAIL timeout_rdata: got %h want %h", rsp_rdata, last_line); end
        tick();
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL timeout_idle: got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read(15'h0005, 128'h8888_7777_6666_5555_4444_3333_2222_1111, 0);
        test_write_busy();
        test_read(15'h0ABC, 128'hC007_C006_C005_C004_C003_C002_C001_C000, 3);
        test_reset_mid();
        test_read(15'h2468, 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878, 0);
`ifdef MEM_BUS_TIMEOUT_EN
        test_timeout();
        test_read(15'h0001, 128'hA1A1_B2B2_C3C3_D4D4_E5E5_F6F6_0707_1818, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, line address width (19-bit byte address minus 4 offset bits).
REQ-002 SHALL have parameter BUS_W, default 16, C2 data bus width.
REQ-003 SHALL have parameter LINE_BITS, default 128, cache line width; beats per line = LINE_BITS/BUS_W = 8.
REQ-004 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles.
REQ-005 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  line request from cache present.
REQ-008 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-009 SHALL have port req_write  input  1  1 = line write-back, 0 = line fill.
REQ-010 SHALL have port req_addr  input  ADDR_W  line address.
REQ-011 SHALL have port req_wdata  input  LINE_BITS  write-back line.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  output  LINE_BITS  filled line, valid with rsp_valid on reads.
REQ-014 SHALL have port rsp_err  output  1  timeout abort flag, valid with rsp_valid.
REQ-015 SHALL have port c2_addr  output  ADDR_W  line address to memory.
REQ-016 SHALL have port c2_cmd  inout  2  C2 command bus: NOP=0, RESPONSE=1, READ=2, WRITE=3.
REQ-017 SHALL have port c2_data  inout  BUS_W  C2 data bus.

Function
REQ-018 SHALL use states IDLE, RD_CMD, RD_WAIT, WR_BEAT, WR_TURN, WR_WAIT, DONE.
REQ-019 SHALL assert req_ready only in IDLE; request accepted on req_valid&req_ready, capturing req_addr/req_write/req_wdata; IDLE->RD_CMD (read) or WR_BEAT (write).
REQ-020 SHALL drive c2_cmd/c2_data only in RD_CMD and WR_BEAT, NOP on c2_cmd in IDLE, high-Z in all other states; c2_addr holds the captured address from acceptance to DONE.
REQ-021 Read: RD_CMD drives READ for exactly one cycle, then RD_WAIT with both buses released.
REQ-022 In RD_WAIT each cycle with c2_cmd==RESPONSE SHALL capture c2_data into beat k (bits 16k+15:16k), k from 0; non-RESPONSE cycles stall without advancing k; after beat 7 go to DONE.
REQ-023 Write: WR_BEAT drives WRITE plus beat k of req_wdata for 8 consecutive cycles (k=0..7), then WR_TURN (one released turnaround cycle), then WR_WAIT.
REQ-024 WR_WAIT SHALL advance to DONE on the first cycle with c2_cmd==RESPONSE.
REQ-025 DONE SHALL pulse rsp_valid for one cycle, then go to IDLE; earliest re-accept is the cycle after DONE.
REQ-026 rsp_rdata SHALL hold its value until the next read completes; rsp_err=0 on normal completion.
REQ-027 Fill latency with zero-wait memory: acceptance at T, READ at T+1, beats T+2..T+9, rsp_valid at T+10.
REQ-028 req_valid while busy SHALL be ignored with no side effect.

Reset
REQ-029 reset SHALL asynchronously force IDLE, release c2_data to high-Z, drive c2_cmd=NOP, clear beat counter, rsp_valid=0, rsp_err=0, rsp_rdata=0, c2_addr=0, req_ready=1 after release.
REQ-030 Reset mid-transaction SHALL abort without rsp_valid; the transaction is lost.

Configuration
REQ-031 With MEM_BUS_TIMEOUT_EN defined, a counter SHALL clear on each RESPONSE and on entry to RD_WAIT/WR_WAIT; reaching TIMEOUT in either wait state forces DONE with rsp_err=1 and rsp_rdata unchanged.
REQ-032 Without MEM_BUS_TIMEOUT_EN, wait states block indefinitely, rsp_err is tied 0, and no counter logic exists.

Structure
REQ-033 Package mem_bus_pkg SHALL hold the C2 command enum, the state enum, and constants ADDR_W/BUS_W/LINE_BITS/BEATS.
REQ-034 Sub-module line_serdes SHALL do beat serialisation (write) and deserialisation (read) with the 3-bit beat counter.

Verification
REQ-035 Read addr 0x0005, memory returns beats 0x1111..0x8888 back-to-back -> READ at T+1, rsp_valid at T+10, rsp_rdata=0x8888777766665555444433332222_1111.
REQ-036 Write addr 0x7FFF, wdata 0x0123...CDEF -> WRITE plus beats 0xCDEF,... on 8 cycles, bus Z in WR_TURN, rsp_valid one cycle after RESPONSE.
REQ-037 Read with NOP gap of 3 cycles after beat 4 -> beats 5..7 land correctly, rsp_valid delayed by exactly 3 cycles.
REQ-038 req_valid held high during a write -> only one transaction, req_ready low until after DONE.
REQ-039 reset asserted at beat 3 of a read -> immediate IDLE, c2_data Z, c2_cmd NOP, no rsp_valid.
REQ-040 MEM_BUS_TIMEOUT_EN, no RESPONSE after READ -> rsp_valid with rsp_err=1 exactly TIMEOUT cycles after RD_WAIT entry.
